la_axis_arbiter: RTL

- Packet-level AXI-Stream arbiter that shares the single upstream AXIS master link between the user-project stream (up_*) and the logic-analyzer trace stream (la_*).
- Honours la_hpri_req as a priority hint and bounds LA preemption with a starvation limit.
- Output goes through a one-beat register slice.
- Sits between LOGIC_ANLZ / user project and the AXIS switch toward the SoC.

---
 rtl/la_pkg.sv | 38 +++
 rtl/axis_reg_slice.sv | 70 +++++++
 rtl/la_axis_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/la_pkg.sv
// ============================================================================
// Module      : la_pkg
// Description : Shared encodings for the LA / user-project AXIS arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package la_pkg;

    localparam logic [1:0] GNT_IDLE = 2'b00;
    localparam logic [1:0] GNT_UP   = 2'b01;
    localparam logic [1:0] GNT_LA   = 2'b10;

    localparam logic [1:0] LA_TUSER_DEFAULT = 2'b10;

    // Field layout of an LA trace beat; the arbiter forwards it untouched.
    localparam int RC_MSB  = 31;
    localparam int RC_LSB  = 24;
    localparam int SIG_MSB = 23;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCK_UP = 2'd1,
        ST_LOCK_LA = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_UP = 1'b0,
        SRC_LA = 1'b1
    } src_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] max);
        return (val >= max) ? max : val + 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_reg_slice.sv
// ============================================================================
// Module      : axis_reg_slice
// Description : Single-beat AXIS output register with slot-free indication.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_reg_slice #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic [DATA_WIDTH-1:0]   i_tdata,
    input  logic [DATA_WIDTH/8-1:0] i_tstrb,
    input  logic [DATA_WIDTH/8-1:0] i_tkeep,
    input  logic                    i_tlast,
    input  logic [USER_WIDTH-1:0]   i_tuser,
    input  logic                    i_tready,
    output logic [DATA_WIDTH-1:0]   o_tdata,
    output logic [DATA_WIDTH/8-1:0] o_tstrb,
    output logic [DATA_WIDTH/8-1:0] o_tkeep,
    output logic                    o_tlast,
    output logic [USER_WIDTH-1:0]   o_tuser,
    output logic                    o_tvalid,
    output logic                    o_slot_free
);

    logic [DATA_WIDTH-1:0]   r_tdata;
    logic [DATA_WIDTH/8-1:0] r_tstrb;
    logic [DATA_WIDTH/8-1:0] r_tkeep;
    logic                    r_tlast;
    logic [USER_WIDTH-1:0]   r_tuser;
    logic                    r_tvalid;

    assign o_slot_free = !r_tvalid || i_tready;

    // i_load is only ever raised while the slot is free, so the payload
    // stays frozen during downstream back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tdata  <= '0;
            r_tstrb  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_tuser  <= '0;
            r_tvalid <= 1'b0;
        end else if (i_load) begin
            r_tdata  <= i_tdata;
            r_tstrb  <= i_tstrb;
            r_tkeep  <= i_tkeep;
            r_tlast  <= i_tlast;
            r_tuser  <= i_tuser;
            r_tvalid <= 1'b1;
        end else if (i_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign o_tdata  = r_tdata;
    assign o_tstrb  = r_tstrb;
    assign o_tkeep  = r_tkeep;
    assign o_tlast  = r_tlast;
    assign o_tuser  = r_tuser;
    assign o_tvalid = r_tvalid;

endmodule

`default_nettype wire

// File: rtl/la_axis_arbiter.sv
// ============================================================================
// Module      : la_axis_arbiter
// Description : Packet-level arbiter merging user-project and LA trace streams.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module la_axis_arbiter
    import la_pkg::*;
#(
    parameter int         pDATA_WIDTH    = 32,
    parameter int         pLA_MAX_CONSEC = 4,
    parameter logic [1:0] pLA_TUSER      = LA_TUSER_DEFAULT
) (
    input  logic                     axis_clk,
    input  logic                     axis_rst_n,
    input  logic [pDATA_WIDTH-1:0]   up_tdata,
    input  logic [pDATA_WIDTH/8-1:0] up_tstrb,
    input  logic [pDATA_WIDTH/8-1:0] up_tkeep,
    input  logic                     up_tlast,
    input  logic [1:0]               up_tuser,
    input  logic                     up_tvalid,
    output logic                     up_tready,
    input  logic [pDATA_WIDTH-1:0]   la_tdata,
    input  logic [pDATA_WIDTH/8-1:0] la_tstrb,
    input  logic [pDATA_WIDTH/8-1:0] la_tkeep,
    input  logic                     la_tlast,
    input  logic                     la_tvalid,
    output logic                     la_tready,
    input  logic                     la_hpri_req,
    output logic [pDATA_WIDTH-1:0]   m_tdata,
    output logic [pDATA_WIDTH/8-1:0] m_tstrb,
    output logic [pDATA_WIDTH/8-1:0] m_tkeep,
    output logic                     m_tlast,
    output logic [1:0]               m_tuser,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [1:0]               grant
);

    localparam logic [3:0] c_LA_MAX = 4'(pLA_MAX_CONSEC);

    arb_state_t r_state;
    src_t       r_last_src;
    logic [3:0] r_consec;
    logic [1:0] r_grant;

    logic w_slot_free;
    logic w_sel_up;
    logic w_sel_la;
    logic w_up_fire;
    logic w_la_fire;

    always_comb begin
        w_sel_up = 1'b0;
        w_sel_la = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (up_tvalid && la_tvalid) begin
                    // Priority hint wins unless the starvation limit is reached.
                    if (la_hpri_req) begin
                        w_sel_up = (r_consec == c_LA_MAX);
                        w_sel_la = (r_consec != c_LA_MAX);
                    end else begin
                        w_sel_up = (r_last_src == SRC_LA);
                        w_sel_la = (r_last_src == SRC_UP);
                    end
                end else begin
                    w_sel_up = up_tvalid;
                    w_sel_la = la_tvalid;
                end
            end
            ST_LOCK_UP: w_sel_up = 1'b1;
            ST_LOCK_LA: w_sel_la = 1'b1;
            default: begin
                w_sel_up = 1'b0;
                w_sel_la = 1'b0;
            end
        endcase
    end

    assign up_tready = w_slot_free && w_sel_up;
    assign la_tready = w_slot_free && w_sel_la;
    assign w_up_fire = up_tvalid && up_tready;
    assign w_la_fire = la_tvalid && la_tready;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= GNT_IDLE;
            r_last_src <= SRC_LA;
            r_consec   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_up_fire) begin
                        r_last_src <= SRC_UP;
                        r_consec   <= 4'd0;
                        if (!up_tlast) begin
                            r_state <= ST_LOCK_UP;
                            r_grant <= GNT_UP;
                        end
                    end else if (w_la_fire) begin
                        r_last_src <= SRC_LA;
                        r_consec   <= up_tvalid ? sat_inc(r_consec, c_LA_MAX) : 4'd0;
                        if (!la_tlast) begin
                            r_state <= ST_LOCK_LA;
                            r_grant <= GNT_LA;
                        end
                    end
                end
                ST_LOCK_UP: begin
                    if (w_up_fire && up_tlast) begin
                        r_state <= ST_IDLE;
                        r_grant <= GNT_IDLE;
                    end
                end
                ST_LOCK_LA: begin
                    if (w_la_fire && la_tlast) begin
                        r_state <= ST_IDLE;
                        r_grant <= GNT_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= GNT_IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;

    axis_reg_slice #(
        .DATA_WIDTH (pDATA_WIDTH),
        .USER_WIDTH (2)
    ) u_slice (
        .clk         (axis_clk),
        .rst_n       (axis_rst_n),
        .i_load      (w_up_fire || w_la_fire),
        .i_tdata     (w_sel_up ? up_tdata : la_tdata),
        .i_tstrb     (w_sel_up ? up_tstrb : la_tstrb),
        .i_tkeep     (w_sel_up ? up_tkeep : la_tkeep),
        .i_tlast     (w_sel_up ? up_tlast : la_tlast),
        .i_tuser     (w_sel_up ? up_tuser : pLA_TUSER),
        .i_tready    (m_tready),
        .o_tdata     (m_tdata),
        .o_tstrb     (m_tstrb),
        .o_tkeep     (m_tkeep),
        .o_tlast     (m_tlast),
        .o_tuser     (m_tuser),
        .o_tvalid    (m_tvalid),
        .o_slot_free (w_slot_free)
    );

endmodule

`default_nettype wire
